// File: rtl/adc_pack_s2mm.sv
// rtl/adc_pack_s2mm.sv - packs dual-channel ADC sample pairs into framed AXI-Stream beats for DMA S2MM

module adc_pack_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)
                count <= count + 1'b1;
            else if (!do_wr && do_rd)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module adc_pack_s2mm #(
    parameter int DATA_WIDTH   = 64,
    parameter int SAMPLE_WIDTH = 12,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    sys_clk,
    input  logic                    perif_rst,
    input  logic                    smp_valid,
    input  logic [SAMPLE_WIDTH-1:0] da_data,
    input  logic [SAMPLE_WIDTH-1:0] db_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic [15:0]             frame_len,
    input  logic [15:0]             frame_num,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    overflow,
    output logic [15:0]             drop_cnt
);
    localparam int PAIRS = DATA_WIDTH / 32;
    localparam int KW    = DATA_WIDTH / 8;
    localparam int CW    = $clog2(PAIRS + 1);
    localparam int BW    = DATA_WIDTH + KW + 1;
    localparam int NW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [15:0]           fl_lat;
    logic [15:0]           fn_lat;
    logic [15:0]           beat_idx;
    logic [15:0]           frame_cnt;
    logic [CW-1:0]         p;
    logic [CW-1:0]         fill;
    logic [DATA_WIDTH-1:0] pack_data;
    logic [DATA_WIDTH-1:0] pack_next;
    logic [DATA_WIDTH-1:0] stg_data;
    logic [KW-1:0]         part_keep;
    logic [KW-1:0]         stg_keep;
    logic                  stg_valid;
    logic                  stg_force_last;
    logic                  stg_last;
    logic [31:0]           pair;
    logic                  accept;
    logic                  beat_full;
    logic                  stop_run;
    logic                  stage_full;
    logic                  stage_part;
    logic                  wr_ok;
    logic                  drop;
    logic                  frame_done;
    logic                  fifo_rd;
    logic                  drained;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [NW-1:0]         fifo_count;
    logic [BW-1:0]         fifo_rd_data;

    assign pair = {16'(db_data), 16'(da_data)};

    // Write stage: the staged beat's tlast and the drop decision are resolved
    // together, so beat_idx only advances for beats that reach the FIFO.
    assign stg_last   = stg_force_last || (beat_idx == fl_lat - 16'd1);
    assign wr_ok      = stg_valid && !fifo_full;
    assign drop       = stg_valid && fifo_full;
    assign frame_done = wr_ok && stg_last && (fn_lat != 16'd0) && (frame_cnt == fn_lat - 16'd1);

    assign accept     = (state == ST_RUN) && smp_valid && !frame_done;
    assign stop_run   = (state == ST_RUN) && stop && !frame_done;
    assign fill       = p + CW'(accept);
    assign beat_full  = (fill == CW'(PAIRS));
    assign stage_full = accept && beat_full;
    assign stage_part = stop_run && !beat_full && (fill != '0);

    assign fifo_rd = m_axis_tvalid && m_axis_tready;
    assign drained = !stg_valid && ((fifo_count == '0) || ((fifo_count == NW'(1)) && fifo_rd));

    always_comb begin
        pack_next = pack_data;
        if (accept) pack_next[32*p +: 32] = pair;
        part_keep = '0;
        for (int k = 0; k < PAIRS; k++) begin
            if (k < int'(fill)) part_keep[4*k +: 4] = 4'hF;
        end
    end

    adc_pack_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (perif_rst),
        .wr_en   (stg_valid),
        .wr_data ({stg_last, stg_keep, stg_data}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_empty ? '0 : fifo_rd_data;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge sys_clk) begin
        if (perif_rst) begin
            state          <= ST_IDLE;
            fl_lat         <= 16'd0;
            fn_lat         <= 16'd0;
            beat_idx       <= 16'd0;
            frame_cnt      <= 16'd0;
            p              <= '0;
            pack_data      <= '0;
            stg_valid      <= 1'b0;
            stg_data       <= '0;
            stg_keep       <= '0;
            stg_force_last <= 1'b0;
            overflow       <= 1'b0;
            drop_cnt       <= 16'd0;
        end else begin
            stg_valid <= stage_full || stage_part;
            if (stage_full || stage_part) begin
                stg_data       <= pack_next;
                stg_keep       <= beat_full ? '1 : part_keep;
                stg_force_last <= stage_part;
            end

            if (wr_ok) begin
                if (stg_last) begin
                    beat_idx  <= 16'd0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    beat_idx <= beat_idx + 16'd1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fl_lat    <= (frame_len == 16'd0) ? 16'd1 : frame_len;
                        fn_lat    <= frame_num;
                        p         <= '0;
                        pack_data <= '0;
                        beat_idx  <= 16'd0;
                        frame_cnt <= 16'd0;
                        overflow  <= 1'b0;
                        drop_cnt  <= 16'd0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The pack register is cleared on every hand-off so unfilled
                    // pairs of a partial beat are already zero.
                    if (accept) begin
                        p         <= beat_full ? '0 : fill;
                        pack_data <= beat_full ? '0 : pack_next;
                    end
                    if (stop_run || frame_done) begin
                        p         <= '0;
                        pack_data <= '0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
